// File: rtl/fir_chk_if.sv
// Bundle between the FIR output checker and whatever drives it: run control,
// the filter stream, the golden-memory write port and the result flags.
interface fir_chk_if #(
    parameter int DATA_W = 22,
    parameter int ADDR_W = 8
);
    logic              start;
    logic [DATA_W-1:0] dout;
    logic              exp_we;
    logic [ADDR_W-1:0] exp_waddr;
    logic [DATA_W-1:0] exp_wdata;
    logic              busy;
    logic              done;
    logic              pass;
    logic              mismatch;
    logic [ADDR_W:0]   err_cnt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] first_err_idx;
    logic              first_err_valid;

    modport master (
        output start, dout, exp_we, exp_waddr, exp_wdata,
        input  busy, done, pass, mismatch, err_cnt, idx, first_err_idx, first_err_valid
    );

    modport slave (
        input  start, dout, exp_we, exp_waddr, exp_wdata,
        output busy, done, pass, mismatch, err_cnt, idx, first_err_idx, first_err_valid
    );
endinterface

// File: rtl/fir_output_checker.sv
// Compares a FIR output stream against a golden vector after a fixed latency
// and reports mismatch count, first failing index and a pass flag.
module fir_output_checker #(
    parameter int DATA_W  = 22,
    parameter int DEPTH   = 256,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 8
) (
    input  logic     clk,
    input  logic     rst,
    fir_chk_if.slave bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]  WAIT_LOAD = CNT_W'((LATENCY > 0) ? (LATENCY - 1) : 0);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W:0]   ERR_ONE   = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_CMP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_wcnt;
    logic [CNT_W-1:0]  w_wcnt_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic [ADDR_W-1:0] r_fe_idx;
    logic [ADDR_W-1:0] w_fe_idx_nxt;
    logic [ADDR_W:0]   r_err;
    logic [ADDR_W:0]   w_err_nxt;
    logic              r_fe_v;
    logic              w_fe_v_nxt;
    logic              r_mis;
    logic              w_mis_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_pass;
    logic              w_pass_nxt;

    logic [DATA_W-1:0] r_exp_mem [DEPTH];
    logic [DATA_W-1:0] w_exp;
    logic              w_idle_or_done;
    logic              w_start_ok;
    logic              w_mem_we;
    logic              w_neq;

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_start_ok     = bus.start && w_idle_or_done;
    assign w_mem_we       = bus.exp_we && w_idle_or_done;
    assign w_exp          = r_exp_mem[r_idx];
    assign w_neq          = (bus.dout != w_exp);

    // Golden memory: no reset so a loaded vector survives rst between runs.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_exp_mem[bus.exp_waddr] <= bus.exp_wdata;
        end
    end

    // Next-state and next-value logic for the run sequencer.
    always_comb begin
        w_state_nxt  = r_state;
        w_wcnt_nxt   = r_wcnt;
        w_idx_nxt    = r_idx;
        w_err_nxt    = r_err;
        w_fe_idx_nxt = r_fe_idx;
        w_fe_v_nxt   = r_fe_v;
        w_mis_nxt    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_start_ok) begin
                    w_err_nxt    = '0;
                    w_fe_idx_nxt = '0;
                    w_fe_v_nxt   = 1'b0;
                    w_idx_nxt    = '0;
                    if (LATENCY == 0) begin
                        w_state_nxt = S_CMP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_wcnt_nxt  = WAIT_LOAD;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_WAIT: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = S_CMP;
                    w_idx_nxt   = '0;
                end else begin
                    w_wcnt_nxt = r_wcnt - CNT_ONE;
                end
            end
            S_CMP: begin
                if (w_neq) begin
                    w_err_nxt = r_err + ERR_ONE;
                    w_mis_nxt = 1'b1;
                    if (!r_fe_v) begin
                        w_fe_idx_nxt = r_idx;
                        w_fe_v_nxt   = 1'b1;
                    end else begin
                        w_fe_idx_nxt = r_fe_idx;
                    end
                end else begin
                    w_mis_nxt = 1'b0;
                end
                // idx holds at the last sample so it never wraps inside a run.
                if (r_idx == LAST_IDX) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_ONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt == S_WAIT) || (w_state_nxt == S_CMP);
        w_done_nxt = (w_state_nxt == S_DONE);
        w_pass_nxt = w_done_nxt && (w_err_nxt == '0);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wcnt   <= '0;
            r_idx    <= '0;
            r_err    <= '0;
            r_fe_idx <= '0;
            r_fe_v   <= 1'b0;
            r_mis    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
        end else begin
            r_wcnt   <= w_wcnt_nxt;
            r_idx    <= w_idx_nxt;
            r_err    <= w_err_nxt;
            r_fe_idx <= w_fe_idx_nxt;
            r_fe_v   <= w_fe_v_nxt;
            r_mis    <= w_mis_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_pass   <= w_pass_nxt;
        end
    end

    assign bus.busy            = r_busy;
    assign bus.done            = r_done;
    assign bus.pass            = r_pass;
    assign bus.mismatch        = r_mis;
    assign bus.err_cnt         = r_err;
    assign bus.idx             = r_idx;
    assign bus.first_err_idx   = r_fe_idx;
    assign bus.first_err_valid = r_fe_v;
endmodule

// File: tb/tb_fir_output_checker.sv
// Scoreboard bench: runs push expected results, monitors pop them when the
// checker raises done or pulses mismatch.
module tb_fir_output_checker;
    localparam int DW    = 22;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int NEV   = -1000;
    localparam logic [DW-1:0] NEW0 = 22'h155555;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fir_chk_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
    fir_chk_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

    fir_output_checker #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(8)) u_dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    fir_output_checker #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .LATENCY(0)) u_dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    typedef struct {
        int done_cyc;
        int err;
        int first;
        bit fv;
        bit pass;
    } res_t;

    res_t dqa[$];
    res_t dqb[$];
    int   mq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic pa_done = 1'b0;
    logic pb_done = 1'b0;
    res_t ra, rb;
    int   me;
    logic [DW-1:0] gold [DEPTH];
    logic [DW-1:0] stim [DEPTH];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic int qsize(input int sel);
        return (sel == 0) ? dqa.size() : dqb.size();
    endfunction

    // Monitor for the LATENCY=8 instance: mismatch pulses and run results.
    always @(negedge clk) begin
        if (ifa.mismatch === 1'b1) begin
            if (mq.size() == 0) begin
                chk("unexpected_mismatch_a", ifa.mismatch, 0);
            end else begin
                me = mq.pop_front();
                chk("mismatch_idx_a", ifa.idx - 1, me);
            end
        end
        if (ifa.done === 1'b1 && pa_done === 1'b0) begin
            if (dqa.size() == 0) begin
                chk("unexpected_done_a", ifa.done, 0);
            end else begin
                ra = dqa.pop_front();
                chk("done_cycle_a", cyc, ra.done_cyc);
                chk("err_cnt_a", ifa.err_cnt, ra.err);
                chk("first_err_idx_a", ifa.first_err_idx, ra.first);
                chk("first_err_valid_a", ifa.first_err_valid, ra.fv);
                chk("pass_a", ifa.pass, ra.pass);
            end
        end
        pa_done <= ifa.done;
    end

    // Monitor for the LATENCY=0 instance: run results.
    always @(negedge clk) begin
        if (ifb.done === 1'b1 && pb_done === 1'b0) begin
            if (dqb.size() == 0) begin
                chk("unexpected_done_b", ifb.done, 0);
            end else begin
                rb = dqb.pop_front();
                chk("done_cycle_b", cyc, rb.done_cyc);
                chk("err_cnt_b", ifb.err_cnt, rb.err);
                chk("first_err_idx_b", ifb.first_err_idx, rb.first);
                chk("first_err_valid_b", ifb.first_err_valid, rb.fv);
                chk("pass_b", ifb.pass, rb.pass);
            end
        end
        pb_done <= ifb.done;
    end

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) ifa.start = v; else ifb.start = v;
    endtask

    task automatic set_dout(input int sel, input logic [DW-1:0] v);
        if (sel == 0) ifa.dout = v; else ifb.dout = v;
    endtask

    task automatic chk_reset_a();
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_pass", ifa.pass, 0);
        chk("rst_mismatch", ifa.mismatch, 0);
        chk("rst_err_cnt", ifa.err_cnt, 0);
        chk("rst_idx", ifa.idx, 0);
        chk("rst_first_err_idx", ifa.first_err_idx, 0);
        chk("rst_first_err_valid", ifa.first_err_valid, 0);
    endtask

    task automatic run(input int sel, input int lat, input bit push, input int exp_err,
                       input int exp_first, input int rst_at, input int prot_at,
                       input bit restart_chk, input bit wr0);
        int   k;
        res_t r;
        @(negedge clk);
        set_start(sel, 1'b1);
        if (wr0) begin
            ifb.exp_we    = 1'b1;
            ifb.exp_waddr = '0;
            ifb.exp_wdata = NEW0;
        end
        k = cyc + 1;
        if (push) begin
            r.done_cyc = k + lat + DEPTH;
            r.err      = exp_err;
            r.first    = exp_first;
            r.fv       = (exp_err != 0);
            r.pass     = (exp_err == 0);
            if (sel == 0) dqa.push_back(r); else dqb.push_back(r);
        end
        @(negedge clk);
        set_start(sel, 1'b0);
        ifb.exp_we = 1'b0;
        if (restart_chk) begin
            chk("restart_err_cnt", ifa.err_cnt, 0);
            chk("restart_first_err_valid", ifa.first_err_valid, 0);
            chk("restart_idx", ifa.idx, 0);
            chk("restart_busy", ifa.busy, 1);
        end
        for (int t = k + 1; t <= k + lat + DEPTH; t++) begin
            int s = t - (k + lat + 1);
            set_dout(sel, (s >= 0 && s < DEPTH) ? stim[s] : '0);
            if (sel == 0) begin
                ifa.start     = (s == prot_at);
                ifa.exp_we    = (s == prot_at);
                ifa.exp_waddr = 8'd5;
                ifa.exp_wdata = 22'h3FFFFF;
            end
            if (s == rst_at) begin
                chk("idx_before_rst", ifa.idx, rst_at);
                rst = 1'b1;
                #1;
                chk_reset_a();
                @(negedge clk);
                rst = 1'b0;
                set_dout(sel, '0);
                return;
            end
            @(negedge clk);
        end
        set_dout(sel, '0);
        ifa.start  = 1'b0;
        ifa.exp_we = 1'b0;
        for (int w = 0; w < 4 && qsize(sel) != 0; w++) @(negedge clk);
        if (qsize(sel) != 0) begin
            chk("done_timeout", (sel == 0) ? ifa.done : ifb.done, 1);
            if (sel == 0) void'(dqa.pop_front()); else void'(dqb.pop_front());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        ifa.start = 1'b0; ifa.dout = '0; ifa.exp_we = 1'b0; ifa.exp_waddr = '0; ifa.exp_wdata = '0;
        ifb.start = 1'b0; ifb.dout = '0; ifb.exp_we = 1'b0; ifb.exp_waddr = '0; ifb.exp_wdata = '0;
        for (int i = 0; i < DEPTH; i++) gold[i] = DW'(22'h00ABCD + i * 22'h001357);
        repeat (3) @(negedge clk);
        chk_reset_a();
        chk("rst_busy_b", ifb.busy, 0);
        chk("rst_done_b", ifb.done, 0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            ifa.exp_we = 1'b1; ifa.exp_waddr = AW'(i); ifa.exp_wdata = gold[i];
            ifb.exp_we = 1'b1; ifb.exp_waddr = AW'(i); ifb.exp_wdata = gold[i];
        end
        @(negedge clk);
        ifa.exp_we = 1'b0;
        ifb.exp_we = 1'b0;

        // Clean run with defaults.
        for (int i = 0; i < DEPTH; i++) stim[i] = gold[i];
        run(0, 8, 1'b1, 0, 0, NEV, NEV, 1'b0, 1'b0);

        // Bit-21 corruption at samples 3, 4 and 200.
        stim[3]   = gold[3]   ^ 22'h200000;
        stim[4]   = gold[4]   ^ 22'h200000;
        stim[200] = gold[200] ^ 22'h200000;
        mq.push_back(3); mq.push_back(4); mq.push_back(200);
        run(0, 8, 1'b1, 3, 3, NEV, NEV, 1'b0, 1'b0);

        // Restart from DONE with a clean stream.
        for (int i = 0; i < DEPTH; i++) stim[i] = gold[i];
        run(0, 8, 1'b1, 0, 0, NEV, NEV, 1'b1, 1'b0);

        // start/exp_we while busy must be ignored.
        run(0, 8, 1'b1, 0, 0, NEV, 2, 1'b0, 1'b0);

        // Reset at idx 100, then a clean run on the retained memory.
        run(0, 8, 1'b0, 0, 0, 100, NEV, 1'b0, 1'b0);
        run(0, 8, 1'b1, 0, 0, NEV, NEV, 1'b0, 1'b0);

        // LATENCY=0: write at the start edge lands before the first compare.
        stim[0] = NEW0;
        run(1, 0, 1'b1, 0, 0, NEV, NEV, 1'b0, 1'b1);

        // LATENCY=0: stream one cycle late fails every sample.
        stim[0] = '0;
        stim[1] = NEW0;
        for (int i = 2; i < DEPTH; i++) stim[i] = gold[i-1];
        run(1, 0, 1'b1, 256, 0, NEV, NEV, 1'b0, 1'b0);

        chk("mismatch_leftover", mq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
